// File: rtl/dm_sized_if.sv
// Request/response bundle between the MEM stage and the sized data memory.
// master drives the request fields; slave returns ack/fault/rdata/busy.
interface dm_sized_if #(
    parameter int ABITS = 9
) ();
    logic             req;
    logic             we;
    logic [1:0]       size;
    logic             sext;
    logic [ABITS-1:0] addr;
    logic [31:0]      wdata;
    logic             ack;
    logic             fault;
    logic [31:0]      rdata;
    logic             busy;

    modport master (
        output req, we, size, sext, addr, wdata,
        input  ack, fault, rdata, busy
    );

    modport slave (
        input  req, we, size, sext, addr, wdata,
        output ack, fault, rdata, busy
    );
endinterface

// File: rtl/dm_sized.sv
// Byte/half/word data memory with alignment faults and a req/ack handshake
// whose completion is delayed by WAIT_CYCLES extra cycles.
module dm_sized #(
    parameter int ABITS       = 9,
    parameter int WAIT_CYCLES = 0
) (
    input logic        clk,
    input logic        rst_n,
    dm_sized_if.slave  bus
);
    localparam int DEPTH = 2 ** (ABITS - 2);

    // ISSUE is the cycle between acceptance and the first wait/completion edge,
    // which gives completion at acceptance + 1 + WAIT_CYCLES with busy only in WAIT.
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state, state_nx;
    logic [3:0]       cnt, cnt_nx;
    logic             accept, complete;

    logic             r_we, r_sext, r_fault;
    logic [1:0]       r_size;
    logic [ABITS-1:0] r_addr;
    logic [31:0]      r_wdata;

    logic             ack_q, fault_q;
    logic [31:0]      rdata_q;

    logic [3:0][7:0]  mem [DEPTH];
    logic [3:0][7:0]  word;
    logic [1:0]       lane;
    logic [15:0]      half;
    logic [31:0]      ld;
    logic             misaligned;

    always_comb begin
        misaligned = (bus.size == 2'b11)
                  || (bus.size == 2'b01 && bus.addr[0])
                  || (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);
    end

    always_comb begin
        accept   = 1'b0;
        complete = 1'b0;
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (bus.req) begin
                    accept   = 1'b1;
                    state_nx = ISSUE;
                    cnt_nx   = WAIT_CYCLES[3:0];
                end
            end
            ISSUE: begin
                if (r_fault || WAIT_CYCLES == 0) begin
                    state_nx = DONE;
                    complete = 1'b1;
                end else begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_nx = DONE;
                    complete = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        word = mem[r_addr[ABITS-1:2]];
        lane = r_addr[1:0];
        half = {word[{lane[1], 1'b1}], word[{lane[1], 1'b0}]};
        case (r_size)
            2'b00:   ld = {{24{r_sext & word[lane][7]}}, word[lane]};
            2'b01:   ld = {{16{r_sext & half[15]}}, half};
            default: ld = word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ack_q   <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            r_we    <= 1'b0;
            r_sext  <= 1'b0;
            r_fault <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ack_q   <= complete;
            fault_q <= complete & r_fault;
            if (complete && !r_fault && !r_we)
                rdata_q <= ld;
            if (accept) begin
                r_we    <= bus.we;
                r_sext  <= bus.sext;
                r_fault <= misaligned;
                r_size  <= bus.size;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
            end
        end
    end

    // Array is not reset; state is IDLE during reset so nothing can commit.
    always_ff @(posedge clk) begin
        if (complete && !r_fault && r_we) begin
            case (r_size)
                2'b00: mem[r_addr[ABITS-1:2]][lane] <= r_wdata[7:0];
                2'b01: begin
                    mem[r_addr[ABITS-1:2]][{lane[1], 1'b0}] <= r_wdata[7:0];
                    mem[r_addr[ABITS-1:2]][{lane[1], 1'b1}] <= r_wdata[15:8];
                end
                default: mem[r_addr[ABITS-1:2]] <= r_wdata;
            endcase
        end
    end

    assign bus.ack   = ack_q;
    assign bus.fault = fault_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = (state == WAIT);
endmodule

// File: tb/tb_dm_sized.sv
// Checks two dm_sized instances (WAIT_CYCLES 0 and 3) against a byte-array
// memory model: directed cases, faults, busy/ignored requests, reset abort, random traffic.
module tb_dm_sized;
    logic clk;
    logic rst0_n, rst3_n;
    logic sel;
    logic t_req, t_we, t_sext;
    logic [1:0]  t_size;
    logic [8:0]  t_addr;
    logic [31:0] t_wdata;
    logic s_ack, s_fault, s_busy;
    logic [31:0] s_rdata;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mdl [2][512];
    logic [31:0] mrd [2];

    dm_sized_if #(.ABITS(9)) b0 ();
    dm_sized_if #(.ABITS(9)) b3 ();

    dm_sized #(.ABITS(9), .WAIT_CYCLES(0)) u0 (.clk(clk), .rst_n(rst0_n), .bus(b0));
    dm_sized #(.ABITS(9), .WAIT_CYCLES(3)) u3 (.clk(clk), .rst_n(rst3_n), .bus(b3));

    assign b0.req   = t_req & ~sel;
    assign b3.req   = t_req & sel;
    assign b0.we    = t_we;
    assign b3.we    = t_we;
    assign b0.size  = t_size;
    assign b3.size  = t_size;
    assign b0.sext  = t_sext;
    assign b3.sext  = t_sext;
    assign b0.addr  = t_addr;
    assign b3.addr  = t_addr;
    assign b0.wdata = t_wdata;
    assign b3.wdata = t_wdata;

    assign s_ack   = sel ? b3.ack   : b0.ack;
    assign s_fault = sel ? b3.fault : b0.fault;
    assign s_busy  = sel ? b3.busy  : b0.busy;
    assign s_rdata = sel ? b3.rdata : b0.rdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One transaction on DUT d (0 -> W=0, 1 -> W=3); poke re-raises req while busy.
    task automatic xact(input bit d, input logic we, input logic [1:0] sz, input logic sx,
                        input logic [8:0] a, input logic [31:0] wd, input bit poke);
        int nb, elat, lat, nbusy, di, wcyc;
        logic ef;
        logic [31:0] v;
        di   = d ? 1 : 0;
        wcyc = d ? 3 : 0;
        nb   = 1 << sz;
        ef   = (sz == 2'd3) || ((int'(a) % nb) != 0);
        elat = ef ? 1 : 1 + wcyc;
        if (!ef) begin
            if (we) begin
                for (int i = 0; i < nb; i++) mdl[di][int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < nb; i++) v = v | (32'(mdl[di][int'(a) + i]) << (8*i));
                if (sx && nb < 4 && mdl[di][int'(a) + nb - 1][7]) v = v | (32'hFFFF_FFFF << (8*nb));
                mrd[di] = v;
            end
        end

        @(negedge clk);
        sel = d; t_we = we; t_size = sz; t_sext = sx; t_addr = a; t_wdata = wd; t_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_req = 1'b0;
        t_wdata = $urandom;
        t_addr  = 9'($urandom_range(63));
        lat = -1;
        nbusy = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (s_busy) nbusy++;
            if (poke) t_req = s_busy;
            if (s_ack) begin
                lat = k;
                break;
            end
        end
        t_req = 1'b0;
        chk("latency", 32'(lat), 32'(elat));
        chk("fault", 32'(s_fault), 32'(ef));
        chk("rdata", s_rdata, mrd[di]);
        if (d && !ef) chk("busy_cycles", 32'(nbusy), 32'd3);
        @(negedge clk);
        chk("ack_pulse", 32'(s_ack), 32'd0);
    endtask

    initial begin
        int nacks;
        rst0_n = 1'b0; rst3_n = 1'b0; sel = 1'b0;
        t_req = 1'b0; t_we = 1'b0; t_size = '0; t_sext = 1'b0; t_addr = '0; t_wdata = '0;
        mrd[0] = '0; mrd[1] = '0;
        repeat (2) @(negedge clk);
        chk("rst_ack0", 32'(b0.ack), 32'd0);
        chk("rst_rdata3", b3.rdata, 32'd0);
        chk("rst_busy3", 32'(b3.busy), 32'd0);
        chk("rst_fault0", 32'(b0.fault), 32'd0);
        rst0_n = 1'b1; rst3_n = 1'b1;

        // Give the model's working region known contents on both instances.
        for (int w = 0; w < 16; w++) begin
            xact(1'b0, 1'b1, 2'd2, 1'b0, 9'(w*4), $urandom, 1'b0);
            xact(1'b1, 1'b1, 2'd2, 1'b0, 9'(w*4), $urandom, 1'b0);
        end

        xact(1'b0, 1'b1, 2'd2, 1'b0, 9'h010, 32'hDEADBEEF, 1'b0);
        xact(1'b0, 1'b0, 2'd2, 1'b0, 9'h010, 32'h0, 1'b0);
        chk("rd_deadbeef", s_rdata, 32'hDEADBEEF);

        xact(1'b0, 1'b1, 2'd2, 1'b0, 9'h010, 32'h11223344, 1'b0);
        xact(1'b0, 1'b1, 2'd0, 1'b0, 9'h013, 32'h00000080, 1'b0);
        xact(1'b0, 1'b0, 2'd0, 1'b1, 9'h013, 32'h0, 1'b0);
        chk("lb_sext", s_rdata, 32'hFFFFFF80);
        xact(1'b0, 1'b0, 2'd0, 1'b0, 9'h013, 32'h0, 1'b0);
        chk("lbu", s_rdata, 32'h00000080);
        xact(1'b0, 1'b0, 2'd2, 1'b0, 9'h010, 32'h0, 1'b0);
        chk("lw_merged", s_rdata, 32'h80223344);

        xact(1'b0, 1'b1, 2'd2, 1'b0, 9'h020, 32'h0, 1'b0);
        xact(1'b0, 1'b1, 2'd1, 1'b0, 9'h022, 32'h0000A5A5, 1'b0);
        xact(1'b0, 1'b0, 2'd1, 1'b1, 9'h022, 32'h0, 1'b0);
        chk("lh_sext", s_rdata, 32'hFFFFA5A5);
        xact(1'b0, 1'b0, 2'd1, 1'b1, 9'h020, 32'h0, 1'b0);
        chk("lh_low", s_rdata, 32'h00000000);

        xact(1'b0, 1'b0, 2'd1, 1'b1, 9'h021, 32'h0, 1'b0);
        xact(1'b0, 1'b1, 2'd2, 1'b0, 9'h016, 32'hCAFEF00D, 1'b0);
        xact(1'b0, 1'b1, 2'd3, 1'b0, 9'h014, 32'hCAFEF00D, 1'b0);
        xact(1'b1, 1'b1, 2'd2, 1'b0, 9'h01A, 32'hCAFEF00D, 1'b0);
        xact(1'b0, 1'b0, 2'd2, 1'b0, 9'h014, 32'h0, 1'b0);
        xact(1'b1, 1'b0, 2'd2, 1'b0, 9'h018, 32'h0, 1'b0);

        xact(1'b1, 1'b0, 2'd2, 1'b0, 9'h010, 32'h0, 1'b1);
        nacks = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (s_ack) nacks++;
        end
        chk("no_extra_ack", 32'(nacks), 32'd0);

        // Store aborted by reset two edges after acceptance must not commit.
        @(negedge clk);
        sel = 1'b1; t_we = 1'b1; t_size = 2'd2; t_sext = 1'b0; t_addr = 9'h030;
        t_wdata = 32'h12345678; t_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        t_req = 1'b0;
        @(negedge clk);
        rst3_n = 1'b0;
        #1;
        chk("abort_ack", 32'(s_ack), 32'd0);
        chk("abort_rdata", s_rdata, 32'd0);
        @(negedge clk);
        rst3_n = 1'b1;
        mrd[1] = '0;
        #1;
        chk("abort_busy", 32'(s_busy), 32'd0);
        chk("post_rst_rdata", s_rdata, 32'd0);
        nacks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (s_ack) nacks++;
        end
        chk("abort_no_ack", 32'(nacks), 32'd0);
        xact(1'b1, 1'b0, 2'd2, 1'b0, 9'h030, 32'h0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            xact(n[0], 1'($urandom), 2'($urandom_range(3)), 1'($urandom),
                 9'($urandom_range(63)), $urandom, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
